// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_pkg
//  Description : Shared definitions for the CPU data-memory access path.
//                Holds memory widths, load/store operation encodings,
//                exception codes, lane-width constants and the op decoder
//                used to classify a request before it is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

    // Memory geometry
    localparam int C_MEM_ADDR_W = 32;
    localparam int C_MEM_DATA_W = 32;
    localparam int C_LANES      = 4;
    localparam int C_LANE_W     = 8;
    localparam int C_HALF_W     = 16;

    // Operation encodings; 4'h8..4'hF are illegal
    localparam logic [3:0] C_OP_LB  = 4'h0;
    localparam logic [3:0] C_OP_LBU = 4'h1;
    localparam logic [3:0] C_OP_LH  = 4'h2;
    localparam logic [3:0] C_OP_LHU = 4'h3;
    localparam logic [3:0] C_OP_LW  = 4'h4;
    localparam logic [3:0] C_OP_SB  = 4'h5;
    localparam logic [3:0] C_OP_SH  = 4'h6;
    localparam logic [3:0] C_OP_SW  = 4'h7;

    // Completion exception codes
    localparam logic [1:0] C_EXCP_NONE        = 2'b00;
    localparam logic [1:0] C_EXCP_LD_MISALIGN = 2'b01;
    localparam logic [1:0] C_EXCP_ST_MISALIGN = 2'b10;
    localparam logic [1:0] C_EXCP_ILLEGAL     = 2'b11;

    typedef enum logic [1:0] {
        ACC_BYTE = 2'd0,
        ACC_HALF = 2'd1,
        ACC_WORD = 2'd2
    } acc_size_e;

    typedef struct packed {
        logic      legal;
        logic      is_store;
        acc_size_e size;
    } op_dec_t;

    function automatic op_dec_t decode_op(input logic [3:0] op);
        op_dec_t d;
        d.legal    = 1'b1;
        d.is_store = 1'b0;
        d.size     = ACC_BYTE;
        case (op)
            C_OP_LB, C_OP_LBU: d.size = ACC_BYTE;
            C_OP_LH, C_OP_LHU: d.size = ACC_HALF;
            C_OP_LW:           d.size = ACC_WORD;
            C_OP_SB: begin d.is_store = 1'b1; d.size = ACC_BYTE; end
            C_OP_SH: begin d.is_store = 1'b1; d.size = ACC_HALF; end
            C_OP_SW: begin d.is_store = 1'b1; d.size = ACC_WORD; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    // Illegal op takes priority over alignment; byte accesses never fault.
    function automatic logic [1:0] check_access(input op_dec_t d, input logic [1:0] off);
        logic misaligned;
        misaligned = ((d.size == ACC_HALF) && off[0]) ||
                     ((d.size == ACC_WORD) && (off != 2'b00));
        if (!d.legal)
            return C_EXCP_ILLEGAL;
        else if (misaligned)
            return d.is_store ? C_EXCP_ST_MISALIGN : C_EXCP_LD_MISALIGN;
        else
            return C_EXCP_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_if
//  Description : Bundle of MEM-stage request/response signals and the data
//                memory bus seen by mem_access_ctrl.
//                slave  : view of the access controller
//                master : view of the surrounding pipeline + memory
//  Signals     : req_i/op_i/addr_i/wdata_i     request from MEM stage
//                stall_o/done_o/rdata_o/excp_o response to MEM stage
//                mem_ce_o/mem_we_o/mem_addr_o/mem_byte_slct_o/mem_data_o
//                                              memory request
//                mem_data_i                    memory read word
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_i;
    logic [3:0]        op_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              stall_o;
    logic              done_o;
    logic [DATA_W-1:0] rdata_o;
    logic [1:0]        excp_o;
    logic              mem_ce_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [3:0]        mem_byte_slct_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;

    modport slave (
        input  req_i, op_i, addr_i, wdata_i, mem_data_i,
        output stall_o, done_o, rdata_o, excp_o,
               mem_ce_o, mem_we_o, mem_addr_o, mem_byte_slct_o, mem_data_o
    );

    modport master (
        output req_i, op_i, addr_i, wdata_i, mem_data_i,
        input  stall_o, done_o, rdata_o, excp_o,
               mem_ce_o, mem_we_o, mem_addr_o, mem_byte_slct_o, mem_data_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_load_align
//  Description : Combinational load extractor. Picks the addressed byte or
//                halfword out of a big-endian memory word (offset 0 is
//                bits [31:24]) and sign- or zero-extends it. Non-load ops
//                return zero.
//  Ports       : i_op     operation code
//                i_offset byte offset within the word
//                i_word   memory read word
//                o_result extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl_load_align
    import mem_access_ctrl_pkg::*;
(
    input  wire logic [3:0]              i_op,
    input  wire logic [1:0]              i_offset,
    input  wire logic [C_MEM_DATA_W-1:0] i_word,
    output logic      [C_MEM_DATA_W-1:0] o_result
);

    logic [C_LANE_W-1:0] w_byte;
    logic [C_HALF_W-1:0] w_half;

    always_comb begin
        w_byte = '0;
        case (i_offset)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];
    end

    always_comb begin
        o_result = '0;
        case (i_op)
            C_OP_LB:  o_result = {{(C_MEM_DATA_W-C_LANE_W){w_byte[C_LANE_W-1]}}, w_byte};
            C_OP_LBU: o_result = {{(C_MEM_DATA_W-C_LANE_W){1'b0}}, w_byte};
            C_OP_LH:  o_result = {{(C_MEM_DATA_W-C_HALF_W){w_half[C_HALF_W-1]}}, w_half};
            C_OP_LHU: o_result = {{(C_MEM_DATA_W-C_HALF_W){1'b0}}, w_half};
            C_OP_LW:  o_result = i_word;
            default:  o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Initiator side of the CPU data-memory interface. Accepts one
//                load/store from the MEM stage, checks alignment, drives the
//                memory request for WAIT_CYCLES+1 cycles, then returns the
//                extended load data (or an exception) with a one-cycle
//                done pulse. Stalls the pipeline while the access is open.
//  Ports       : clk  system clock, rising edge
//                rst  asynchronous active-high reset
//                bus  mem_access_ctrl_if.slave (MEM-stage handshake + memory)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input wire logic         clk,
    input wire logic         rst,
    mem_access_ctrl_if.slave bus
);
    import mem_access_ctrl_pkg::*;

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_ACCESS = 2'd1;
    localparam logic [1:0] C_ST_DONE   = 2'd2;

    localparam int         C_CNT_W     = 4;
    localparam logic [C_CNT_W-1:0] C_WAIT_INIT = C_CNT_W'(WAIT_CYCLES);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [3:0]          r_op;
    logic                r_is_store;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_excp;

    op_dec_t             w_dec;
    logic [1:0]          w_excp;
    logic [DATA_W-1:0]   w_load_result;
    logic [C_LANES-1:0]  w_st_slct;
    logic [DATA_W-1:0]   w_st_data;

    logic                w_stall;
    logic                w_done;
    logic [DATA_W-1:0]   w_rdata;
    logic [1:0]          w_excp_out;
    logic                w_mem_ce;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [C_LANES-1:0]  w_mem_slct;
    logic [DATA_W-1:0]   w_mem_data;

    // Request classification happens on the raw inputs in the accept cycle
    assign w_dec  = decode_op(bus.op_i);
    assign w_excp = check_access(w_dec, bus.addr_i[1:0]);

    mem_access_ctrl_load_align u_load_align (
        .i_op     (r_op),
        .i_offset (r_addr[1:0]),
        .i_word   (bus.mem_data_i),
        .o_result (w_load_result)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= C_ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (bus.req_i)
                    w_next_state = (w_excp != C_EXCP_NONE) ? C_ST_DONE : C_ST_ACCESS;
            end
            C_ST_ACCESS: begin
                if (r_cnt == '0)
                    w_next_state = C_ST_DONE;
            end
            C_ST_DONE:   w_next_state = C_ST_IDLE;
            default:     w_next_state = C_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, wait counter and result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_is_store <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_excp     <= C_EXCP_NONE;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (bus.req_i) begin
                        r_op       <= bus.op_i;
                        r_is_store <= w_dec.is_store;
                        r_addr     <= bus.addr_i;
                        r_wdata    <= bus.wdata_i;
                        r_excp     <= w_excp;
                        r_cnt      <= C_WAIT_INIT;
                        // Cleared so exception and store completions read 0
                        r_rdata    <= '0;
                    end
                end
                C_ST_ACCESS: begin
                    // load_align yields 0 for store ops, so stores return 0
                    if (r_cnt == '0)
                        r_rdata <= w_load_result;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Store lane selection (big-endian: select bit0 is data[31:24])
    // ------------------------------------------------------------------
    always_comb begin
        w_st_slct = '0;
        w_st_data = '0;
        case (r_op)
            C_OP_SB: begin
                w_st_slct = 4'b0001 << r_addr[1:0];
                w_st_data = {C_LANES{r_wdata[C_LANE_W-1:0]}};
            end
            C_OP_SH: begin
                w_st_slct = r_addr[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{r_wdata[C_HALF_W-1:0]}};
            end
            C_OP_SW: begin
                w_st_slct = 4'b1111;
                w_st_data = r_wdata;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_stall    = 1'b0;
        w_done     = 1'b0;
        w_rdata    = '0;
        w_excp_out = C_EXCP_NONE;
        w_mem_ce   = 1'b0;
        w_mem_we   = 1'b0;
        w_mem_addr = '0;
        w_mem_slct = '0;
        w_mem_data = '0;
        case (r_state)
            C_ST_IDLE: begin
                // Stall must drop with reset even if the stage holds req_i
                w_stall = bus.req_i & ~rst;
            end
            C_ST_ACCESS: begin
                w_stall    = 1'b1;
                w_mem_ce   = 1'b1;
                w_mem_addr = r_addr;
                if (r_is_store) begin
                    w_mem_we   = 1'b1;
                    w_mem_slct = w_st_slct;
                    w_mem_data = w_st_data;
                end
            end
            C_ST_DONE: begin
                w_done     = 1'b1;
                w_rdata    = r_rdata;
                w_excp_out = r_excp;
            end
            default: ;
        endcase
    end

    assign bus.stall_o         = w_stall;
    assign bus.done_o          = w_done;
    assign bus.rdata_o         = w_rdata;
    assign bus.excp_o          = w_excp_out;
    assign bus.mem_ce_o        = w_mem_ce;
    assign bus.mem_we_o        = w_mem_we;
    assign bus.mem_addr_o      = w_mem_addr;
    assign bus.mem_byte_slct_o = w_mem_slct;
    assign bus.mem_data_o      = w_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Self-checking bench. Three controllers with WAIT_CYCLES of
//                1, 0 and 3 receive identical requests; each has its own
//                behavioural word memory. Expected results come from a
//                byte-level reference model of the load/store rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int N_DUT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N_DUT-1:0] req;
    logic [3:0]       op;
    logic [31:0]      addr;
    logic [31:0]      wdata;

    logic [N_DUT-1:0] stall, done, ce, we;
    logic [31:0]      rdata [N_DUT];
    logic [1:0]       excp  [N_DUT];
    logic [31:0]      maddr [N_DUT];
    logic [31:0]      mdata [N_DUT];
    logic [3:0]       slct  [N_DUT];

    logic [31:0]      ref_mem [64];
    logic [31:0]      got_rdata [N_DUT];
    logic [1:0]       got_excp  [N_DUT];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            16:      return 32'h11223344;
            17:      return 32'h80F0FF7F;
            default: return (32'(i) * 32'h01020304) ^ 32'hA5C35A3C;
        endcase
    endfunction

    function automatic int wait_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    endfunction

    // ------------------------------------------------------------------
    // Controllers, each with its own memory responder
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        mem_access_ctrl_if bus ();
        logic [31:0] mem [64];

        mem_access_ctrl #(.WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3))) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.req_i      = req[g];
        assign bus.op_i       = op;
        assign bus.addr_i     = addr;
        assign bus.wdata_i    = wdata;
        assign bus.mem_data_i = mem[bus.mem_addr_o[7:2]];

        assign stall[g] = bus.stall_o;
        assign done[g]  = bus.done_o;
        assign rdata[g] = bus.rdata_o;
        assign excp[g]  = bus.excp_o;
        assign ce[g]    = bus.mem_ce_o;
        assign we[g]    = bus.mem_we_o;
        assign maddr[g] = bus.mem_addr_o;
        assign slct[g]  = bus.mem_byte_slct_o;
        assign mdata[g] = bus.mem_data_o;

        initial begin
            for (int i = 0; i < 64; i++) mem[i] = init_word(i);
            forever begin
                @(posedge clk);
                if (bus.mem_ce_o && bus.mem_we_o)
                    for (int k = 0; k < 4; k++)
                        if (bus.mem_byte_slct_o[k])
                            mem[bus.mem_addr_o[7:2]][31-8*k -: 8] = bus.mem_data_o[31-8*k -: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helper
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: byte-addressed big-endian memory semantics.
    // Updates ref_mem for stores.
    // ------------------------------------------------------------------
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd,
                         output logic [1:0] e_excp, output logic [31:0] e_rdata,
                         output logic e_store, output logic [3:0] e_slct, output logic [31:0] e_data);
        int     size;
        int     off;
        bit     st;
        longint w, val, lim;
        e_excp = 2'b00; e_rdata = '0; e_store = 1'b0; e_slct = '0; e_data = '0;
        if (o > 4'd7) begin
            e_excp = 2'b11;
        end else begin
            st   = (o >= 4'd5);
            size = (o == 4'd0 || o == 4'd1 || o == 4'd5) ? 1 :
                   (o == 4'd2 || o == 4'd3 || o == 4'd6) ? 2 : 4;
            off  = int'(a[1:0]);
            if ((off % size) != 0) begin
                e_excp = st ? 2'b10 : 2'b01;
            end else if (!st) begin
                w   = longint'(ref_mem[a[7:2]]);
                lim = longint'(1) << (8 * size);
                val = (w >> (8 * (4 - off - size))) % lim;
                if ((o == 4'd0 || o == 4'd2) && val >= lim / 2)
                    val = val - lim;
                e_rdata = 32'(val);
            end else begin
                e_store = 1'b1;
                for (int j = 0; j < size; j++) begin
                    e_slct[off + j] = 1'b1;
                    ref_mem[a[7:2]][31-8*(off+j) -: 8] = 8'((wd >> (8 * (size - 1 - j))) & 32'hFF);
                end
                e_data = (size == 1) ? 32'(wd[7:0])  * 32'h01010101 :
                         (size == 2) ? 32'(wd[15:0]) * 32'h00010001 : wd;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // One request applied to all controllers; watched cycle by cycle.
    // Cycle 0 is the accept cycle.
    // ------------------------------------------------------------------
    task automatic run_txn(input string tag, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] wd);
        logic [1:0]       e_excp;
        logic [31:0]      e_rdata, e_data;
        logic             e_store;
        logic [3:0]       e_slct;
        logic [N_DUT-1:0] fin;
        int               lat [N_DUT];
        int               cyc;
        model(o, a, wd, e_excp, e_rdata, e_store, e_slct, e_data);
        for (int g = 0; g < N_DUT; g++)
            lat[g] = (e_excp != 2'b00) ? 1 : 2 + wait_of(g);
        @(negedge clk);
        op = o; addr = a; wdata = wd; req = '1;
        fin = '0;
        cyc = 0;
        forever begin
            #1;
            for (int g = 0; g < N_DUT; g++) begin
                if (!fin[g]) begin
                    if (cyc == lat[g]) begin
                        chk($sformatf("%s w%0d done", tag, wait_of(g)), 32'(done[g]), 32'd1);
                        chk($sformatf("%s w%0d rdata", tag, wait_of(g)), rdata[g], e_rdata);
                        chk($sformatf("%s w%0d excp", tag, wait_of(g)), 32'(excp[g]), 32'(e_excp));
                        chk($sformatf("%s w%0d stall_done", tag, wait_of(g)), 32'(stall[g]), 32'd0);
                        chk($sformatf("%s w%0d ce_done", tag, wait_of(g)), 32'(ce[g]), 32'd0);
                        got_rdata[g] = rdata[g];
                        got_excp[g]  = excp[g];
                        fin[g] = 1'b1;
                    end else begin
                        chk($sformatf("%s w%0d done_early c%0d", tag, wait_of(g), cyc), 32'(done[g]), 32'd0);
                        chk($sformatf("%s w%0d stall c%0d", tag, wait_of(g), cyc), 32'(stall[g]), 32'd1);
                        if (e_excp == 2'b00 && cyc >= 1) begin
                            chk($sformatf("%s w%0d ce c%0d", tag, wait_of(g), cyc), 32'(ce[g]), 32'd1);
                            chk($sformatf("%s w%0d addr", tag, wait_of(g)), maddr[g], a);
                            chk($sformatf("%s w%0d we", tag, wait_of(g)), 32'(we[g]), 32'(e_store));
                            chk($sformatf("%s w%0d slct", tag, wait_of(g)), 32'(slct[g]), 32'(e_slct));
                            chk($sformatf("%s w%0d wdata", tag, wait_of(g)), mdata[g], e_data);
                        end else begin
                            chk($sformatf("%s w%0d ce_idle c%0d", tag, wait_of(g), cyc), 32'(ce[g]), 32'd0);
                        end
                    end
                end
            end
            if (fin == '1 || cyc >= 8) break;
            @(negedge clk);
            req = ~fin;
            cyc++;
        end
    endtask

    // ------------------------------------------------------------------
    // Directed then randomized sequence
    // ------------------------------------------------------------------
    initial begin
        logic [3:0]  r_o;
        logic [31:0] r_a;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        rst = 1'b1; req = '0; op = '0; addr = '0; wdata = '0;

        // Reset state, including stall held low against a pending request
        repeat (2) @(negedge clk);
        req = '1;
        #1;
        for (int g = 0; g < N_DUT; g++) begin
            chk("rst stall", 32'(stall[g]), 32'd0);
            chk("rst done",  32'(done[g]),  32'd0);
            chk("rst rdata", rdata[g],      32'd0);
            chk("rst ce",    32'(ce[g]),    32'd0);
        end
        @(negedge clk);
        req = '0;
        rst = 1'b0;

        // Word 0x40 = 0x11223344
        run_txn("lb41", C_OP_LB, 32'h41, 32'h0);
        chk("plan lb41", got_rdata[0], 32'h00000022);
        run_txn("lh42", C_OP_LH, 32'h42, 32'h0);
        chk("plan lh42", got_rdata[0], 32'h00003344);
        run_txn("lw40", C_OP_LW, 32'h40, 32'h0);
        chk("plan lw40", got_rdata[0], 32'h11223344);

        // Word 0x44 = 0x80F0FF7F
        run_txn("lb44", C_OP_LB, 32'h44, 32'h0);
        chk("plan lb44", got_rdata[0], 32'hFFFFFF80);
        run_txn("lbu44", C_OP_LBU, 32'h44, 32'h0);
        chk("plan lbu44", got_rdata[0], 32'h00000080);
        run_txn("lh46", C_OP_LH, 32'h46, 32'h0);
        chk("plan lh46", got_rdata[0], 32'hFFFFFF7F);
        run_txn("lhu46", C_OP_LHU, 32'h46, 32'h0);
        chk("plan lhu46", got_rdata[0], 32'h0000FF7F);

        // Byte store then read-back
        run_txn("sb42", C_OP_SB, 32'h42, 32'h000000AB);
        chk("plan sb42 rdata", got_rdata[0], 32'h0);
        run_txn("lw40b", C_OP_LW, 32'h40, 32'h0);
        chk("plan lw40 after sb", got_rdata[0], 32'h1122AB44);

        // Exceptions
        run_txn("lw41", C_OP_LW, 32'h41, 32'h0);
        chk("plan lw41 excp", 32'(got_excp[0]), 32'h1);
        run_txn("sh43", C_OP_SH, 32'h43, 32'h1234);
        chk("plan sh43 excp", 32'(got_excp[0]), 32'h2);
        run_txn("opF", 4'hF, 32'h40, 32'h0);
        chk("plan opF excp", 32'(got_excp[0]), 32'h3);

        // Reset while all controllers are in ACCESS
        @(negedge clk);
        op = C_OP_LW; addr = 32'h48; wdata = '0; req = '1;
        @(negedge clk);
        #1;
        for (int g = 0; g < N_DUT; g++)
            chk("pre-rst ce", 32'(ce[g]), 32'd1);
        rst = 1'b1;
        #1;
        for (int g = 0; g < N_DUT; g++) begin
            chk("midrst stall", 32'(stall[g]), 32'd0);
            chk("midrst done",  32'(done[g]),  32'd0);
            chk("midrst ce",    32'(ce[g]),    32'd0);
            chk("midrst addr",  maddr[g],      32'd0);
            chk("midrst rdata", rdata[g],      32'd0);
            chk("midrst excp",  32'(excp[g]),  32'd0);
        end
        repeat (2) begin
            @(negedge clk);
            #1;
            for (int g = 0; g < N_DUT; g++)
                chk("rst no done", 32'(done[g]), 32'd0);
        end
        req = '0;
        rst = 1'b0;
        run_txn("post-rst lw40", C_OP_LW, 32'h40, 32'h0);
        chk("plan post-rst lw40", got_rdata[2], 32'h1122AB44);

        // Randomized traffic in the 0x40..0x7F window
        for (int n = 0; n < 40; n++) begin
            r_o = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            r_a = 32'h40 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (r_o == C_OP_LH || r_o == C_OP_LHU || r_o == C_OP_SH) r_a[0] = 1'b0;
                if (r_o == C_OP_LW || r_o == C_OP_SW) r_a[1:0] = 2'b00;
            end
            run_txn($sformatf("rnd%0d", n), r_o, r_a, $urandom);
        end

        @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the CPU data-memory interface; sits between the MEM pipeline stage and the word-addressed data memory.
- Accepts one load/store request at a time and checks address alignment.
- Drives ce/we/addr/byte-select/write-data to memory, holds them for a configurable number of wait cycles, then returns aligned, sign- or zero-extended load data.
- Stalls the pipeline while an access is in flight.

Parameters:
- WAIT_CYCLES, 1, extra cycles the memory request is held before read data is sampled (0..15).
- ADDR_W, 32, byte address width.
- DATA_W, 32, memory word width; fixed at 32 for byte-lane logic.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_i  in  1  MEM stage requests an access; held until done_o.
- op_i  in  4  operation code: LB, LBU, LH, LHU, LW, SB, SH, SW (shared package).
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-justified.
- stall_o  out  1  pipeline stall request.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  extended load result; valid while done_o=1.
- excp_o  out  2  00 none, 01 load misaligned, 10 store misaligned, 11 illegal op; valid while done_o=1.
- mem_ce_o  out  1  memory chip enable.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  32  byte address to memory.
- mem_byte_slct_o  out  4  lane enables; bit0 = data[31:24], bit3 = data[7:0].
- mem_data_o  out  32  lane-replicated store data.
- mem_data_i  in  32  memory read word.

Behaviour:
- Async reset (rst=1): state IDLE; all outputs 0, including stall_o, done_o, rdata_o, excp_o and all mem_*_o. Reset mid-access abandons the access immediately; no done_o pulse.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On req_i=1, latch op_i, addr_i and wdata_i, and decode.
  - Illegal op: go to DONE with excp 11.
  - Misaligned access: go to DONE with excp 01 or 10. LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0. No memory access is made.
  - Otherwise go to ACCESS with wait counter = WAIT_CYCLES.
- ACCESS:
  - Drive mem_ce_o=1 and mem_addr_o = latched address; both stable the whole state.
  - Decrement the counter each cycle. When the counter is 0, sample mem_data_i and go to DONE.
  - Duration is WAIT_CYCLES+1 cycles.
- Byte endianness is big-endian: offset 0 is bits [31:24].
- Store driving (mem_we_o=1 throughout ACCESS):
  - SB: byte_slct one-hot at bit addr[1:0]; data = {4{wdata[7:0]}}.
  - SH: byte_slct 4'b0011 (offset 0) or 4'b1100 (offset 2); data = {2{wdata[15:0]}}.
  - SW: byte_slct 4'b1111; data = wdata.
- Loads: mem_we_o=0, byte_slct=0, mem_data_o=0.
- Load extraction:
  - LB/LBU select byte [31-8*off -: 8].
  - LH/LHU select [31:16] at off 0 and [15:0] at off 2.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- DONE:
  - done_o=1 for exactly one cycle with rdata_o and excp_o valid; all mem_*_o = 0.
  - Unconditional return to IDLE.
  - req_i seen in DONE is ignored; the stage drops or updates it after done_o.
- stall_o:
  - 1 in the IDLE acceptance cycle (combinational from req_i) and throughout ACCESS.
  - 0 in DONE.
  - Pipeline advances on the done_o cycle.
- rdata_o/excp_o hold 0 outside DONE; store completions return rdata_o=0.
- Latency: accept at cycle T; done_o at T+2+WAIT_CYCLES for valid accesses, T+1 for exceptions.
- Back-to-back: a new request is accepted in the IDLE cycle after DONE, giving a minimum spacing of WAIT_CYCLES+3 cycles.

Decomposition:
- Op encodings (OP_LB..OP_SW), exception codes and lane-width constants go in the shared define file alongside the existing memory widths.
- One combinational sub-module, load_align (op, offset, word -> extended result).
- Store lane/byte-select generation stays inline in mem_access_ctrl.

Test Plan:
- Memory word at 0x40 = 0x11223344, WAIT_CYCLES=1: LB 0x41 -> rdata 0x00000022; LH 0x42 -> 0x00003344; LW 0x40 -> 0x11223344; done_o at T+3 each.
- Word at 0x44 = 0x80F0FF7F: LB 0x44 -> 0xFFFFFF80; LBU 0x44 -> 0x00000080; LH 0x46 -> 0xFFFFFF7F; LHU 0x46 -> 0x0000FF7F.
- SB 0x42, wdata 0xAB: mem byte_slct 4'b0100, data 0xABABABAB, we=1 for 2 cycles; then LW 0x40 -> 0x1122AB44.
- Misaligned: LW 0x41 -> excp 01 at T+1, no mem_ce_o; SH 0x43 -> excp 10; op 4'hF -> excp 11.
- Assert rst during ACCESS: all outputs 0 the same cycle, no done_o; next request completes normally.
- WAIT_CYCLES=0 and 3: done_o at T+2 and T+5; stall_o high exactly from the accept cycle to the cycle before done_o.
